// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-stage results and pipeline control in, register-file
// write port, forwarding tap and retire counter out.
interface mem_wb_stage_if #(
    parameter int CNT_W = 32
);
    logic             stall_i;
    logic             flush_i;
    logic             mem_valid;
    logic             mem_regwr;
    logic [4:0]       mem_rw;
    logic [1:0]       mem_wbsel;
    logic [2:0]       mem_ldtype;
    logic [31:0]      mem_alu_res;
    logic [31:0]      mem_rdata;
    logic [31:0]      mem_pc;

    logic             reg_fileWr;
    logic [4:0]       Rw;
    logic [31:0]      busW;
    logic             wb_valid;
    logic             fwd_en;
    logic [4:0]       fwd_rw;
    logic [31:0]      fwd_data;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output stall_i, flush_i, mem_valid, mem_regwr, mem_rw, mem_wbsel,
               mem_ldtype, mem_alu_res, mem_rdata, mem_pc,
        input  reg_fileWr, Rw, busW, wb_valid, fwd_en, fwd_rw, fwd_data,
               retire_cnt
    );

    modport slave (
        input  stall_i, flush_i, mem_valid, mem_regwr, mem_rw, mem_wbsel,
               mem_ldtype, mem_alu_res, mem_rdata, mem_pc,
        output reg_fileWr, Rw, busW, wb_valid, fwd_en, fwd_rw, fwd_data,
               retire_cnt
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back: load alignment, write-back source
// select, register-file write port, WB forwarding tap and retire counter.
module mem_wb_stage #(
    parameter logic [31:0] LINK_OFS = 32'd4,
    parameter int          CNT_W    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_wb_stage_if.slave bus
);
    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2,
        WB_RSVD = 2'd3
    } wbsel_e;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ldtype_e;

    logic             valid_q;
    logic             regwr_q;
    logic             written_q;
    logic [4:0]       rw_q;
    logic [1:0]       wbsel_q;
    logic [2:0]       ldtype_q;
    logic [31:0]      alu_q;
    logic [31:0]      rdata_q;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0]      byte_word;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;
    logic [31:0]      link_sum;
    logic [31:0]      wb_data;
    logic             wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            regwr_q   <= 1'b0;
            written_q <= 1'b0;
            rw_q      <= '0;
            wbsel_q   <= '0;
            ldtype_q  <= '0;
            alu_q     <= '0;
            rdata_q   <= '0;
            pc_q      <= '0;
        end else if (bus.flush_i) begin
            valid_q   <= 1'b0;
            regwr_q   <= 1'b0;
            written_q <= 1'b0;
            rw_q      <= '0;
            wbsel_q   <= '0;
            ldtype_q  <= '0;
            alu_q     <= '0;
            rdata_q   <= '0;
            pc_q      <= '0;
        end else if (bus.stall_i) begin
            // Held entry already had its one WB cycle; block repeat write/retire.
            written_q <= written_q | valid_q;
        end else begin
            valid_q   <= bus.mem_valid;
            regwr_q   <= bus.mem_regwr;
            written_q <= 1'b0;
            rw_q      <= bus.mem_rw;
            wbsel_q   <= bus.mem_wbsel;
            ldtype_q  <= bus.mem_ldtype;
            alu_q     <= bus.mem_alu_res;
            rdata_q   <= bus.mem_rdata;
            pc_q      <= bus.mem_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (valid_q && !written_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        byte_word = rdata_q >> {alu_q[1:0], 3'b000};
        ld_byte   = byte_word[7:0];
        ld_half   = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        ld_data   = rdata_q;
        case (ldtype_q)
            LD_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            LD_BU:   ld_data = {24'h0, ld_byte};
            LD_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            LD_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = rdata_q;
        endcase
    end

    always_comb begin
        // Link value is a word address; the register file rescales r31 by 4.
        link_sum = pc_q + LINK_OFS;
        wb_data  = alu_q;
        case (wbsel_q)
            WB_MEM:  wb_data = ld_data;
            WB_LINK: wb_data = {2'b00, link_sum[31:2]};
            default: wb_data = alu_q;
        endcase
        wr_en = valid_q & regwr_q & (rw_q != 5'd0) & ~written_q;
    end

    assign bus.reg_fileWr = wr_en;
    assign bus.Rw         = rw_q;
    assign bus.busW       = wb_data;
    assign bus.wb_valid   = valid_q;
    assign bus.fwd_en     = wr_en;
    assign bus.fwd_rw     = rw_q;
    assign bus.fwd_data   = wb_data;
    assign bus.retire_cnt = cnt_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: scoreboard of expected WB outputs per edge.
module tb_mem_wb_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_wb_stage_if #(.CNT_W(32)) bus ();

    mem_wb_stage #(.LINK_OFS(32'd4), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [4:0]  rw;
        logic [31:0] busw;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model of WB occupancy, for wb_valid and retire count.
    logic        m_valid   = 1'b0;
    logic        m_written = 1'b0;
    logic [31:0] m_cnt     = '0;

    task automatic drive(input logic v, input logic wr, input logic [4:0] rw,
                         input logic [1:0] sel, input logic [2:0] ld,
                         input logic [31:0] alu, input logic [31:0] rd,
                         input logic [31:0] pc);
        bus.mem_valid   = v;
        bus.mem_regwr   = wr;
        bus.mem_rw      = rw;
        bus.mem_wbsel   = sel;
        bus.mem_ldtype  = ld;
        bus.mem_alu_res = alu;
        bus.mem_rdata   = rd;
        bus.mem_pc      = pc;
    endtask

    task automatic step(input string name, input logic ewe, input logic [4:0] erw,
                        input logic [31:0] ebus);
        exp_t e;
        exp_t g;
        if (m_valid && !m_written) m_cnt = m_cnt + 1;
        if (bus.flush_i) begin
            m_valid   = 1'b0;
            m_written = 1'b0;
        end else if (bus.stall_i) begin
            m_written = m_written | m_valid;
        end else begin
            m_valid   = bus.mem_valid;
            m_written = 1'b0;
        end
        e.name = name; e.we = ewe; e.rw = erw; e.busw = ebus;
        e.valid = m_valid; e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        checks++;
        if (bus.wb_valid !== g.valid) begin
            errors++; $display("FAIL %s wb_valid got %0b exp %0b", g.name, bus.wb_valid, g.valid);
        end
        checks++;
        if (bus.reg_fileWr !== g.we || bus.fwd_en !== g.we) begin
            errors++; $display("FAIL %s we got %0b/%0b exp %0b", g.name, bus.reg_fileWr, bus.fwd_en, g.we);
        end
        checks++;
        if (bus.Rw !== g.rw || bus.fwd_rw !== g.rw) begin
            errors++; $display("FAIL %s rw got %0d/%0d exp %0d", g.name, bus.Rw, bus.fwd_rw, g.rw);
        end
        checks++;
        if (bus.busW !== g.busw || bus.fwd_data !== g.busw) begin
            errors++; $display("FAIL %s busW got %h/%h exp %h", g.name, bus.busW, bus.fwd_data, g.busw);
        end
        checks++;
        if (bus.retire_cnt !== g.cnt) begin
            errors++; $display("FAIL %s retire_cnt got %0d exp %0d", g.name, bus.retire_cnt, g.cnt);
        end
    endtask

    task automatic idle(input string name);
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, '0, '0, '0);
        step(name, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (bus.wb_valid !== 1'b0 || bus.reg_fileWr !== 1'b0 || bus.Rw !== 5'd0 ||
            bus.busW !== 32'h0 || bus.fwd_en !== 1'b0 || bus.fwd_rw !== 5'd0 ||
            bus.fwd_data !== 32'h0 || bus.retire_cnt !== 32'h0) begin
            errors++;
            $display("FAIL %s got v=%0b we=%0b rw=%0d busW=%h fwd=%0b/%0d/%h cnt=%0d exp all zero",
                     name, bus.wb_valid, bus.reg_fileWr, bus.Rw, bus.busW, bus.fwd_en,
                     bus.fwd_rw, bus.fwd_data, bus.retire_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, '0, '0, '0);
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_loads();
        drive(1'b1, 1'b1, 5'd3, 2'd1, 3'd1, 32'h1003, 32'h80FF_1234, 32'h100);
        step("lb_lane3", 1'b1, 5'd3, 32'hFFFF_FF80);
        drive(1'b1, 1'b1, 5'd3, 2'd1, 3'd2, 32'h1003, 32'h80FF_1234, 32'h104);
        step("lbu_lane3", 1'b1, 5'd3, 32'h0000_0080);
        drive(1'b1, 1'b1, 5'd3, 2'd1, 3'd1, 32'h1000, 32'h80FF_1234, 32'h108);
        step("lb_lane0", 1'b1, 5'd3, 32'h0000_0034);
        drive(1'b1, 1'b1, 5'd3, 2'd1, 3'd1, 32'h1002, 32'h80FF_1234, 32'h108);
        step("lb_lane2", 1'b1, 5'd3, 32'hFFFF_FFFF);
        drive(1'b1, 1'b1, 5'd4, 2'd1, 3'd3, 32'h2002, 32'h8001_7FFF, 32'h10C);
        step("lh_upper", 1'b1, 5'd4, 32'hFFFF_8001);
        drive(1'b1, 1'b1, 5'd4, 2'd1, 3'd4, 32'h2001, 32'h8001_7FFF, 32'h110);
        step("lhu_lower", 1'b1, 5'd4, 32'h0000_7FFF);
        drive(1'b1, 1'b1, 5'd4, 2'd1, 3'd4, 32'h2003, 32'h8001_7FFF, 32'h110);
        step("lhu_upper", 1'b1, 5'd4, 32'h0000_8001);
        drive(1'b1, 1'b1, 5'd8, 2'd1, 3'd0, 32'h2001, 32'h8001_7FFF, 32'h114);
        step("lw", 1'b1, 5'd8, 32'h8001_7FFF);
        drive(1'b1, 1'b1, 5'd8, 2'd1, 3'd7, 32'h2003, 32'hCAFE_F00D, 32'h118);
        step("ld_type7_as_lw", 1'b1, 5'd8, 32'hCAFE_F00D);
        idle("loads_idle");
    endtask

    task automatic test_link();
        drive(1'b1, 1'b1, 5'd31, 2'd2, 3'd0, 32'h1111_2222, 32'h3333_4444, 32'h0000_3000);
        step("link", 1'b1, 5'd31, 32'h0000_0C01);
        drive(1'b1, 1'b1, 5'd9, 2'd3, 3'd1, 32'h0000_0055, 32'hFFFF_FFFF, 32'h0000_3004);
        step("wbsel3_as_alu", 1'b1, 5'd9, 32'h0000_0055);
    endtask

    task automatic test_r0();
        drive(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 32'hDEAD_BEEF, '0, 32'h200);
        step("r0_nowrite", 1'b0, 5'd0, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 5'd10, 2'd0, 3'd0, 32'h0000_0777, '0, 32'h204);
        step("regwr0_nowrite", 1'b0, 5'd10, 32'h0000_0777);
        idle("r0_idle");
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 32'h1234_5678, '0, 32'h300);
        step("stall_first", 1'b1, 5'd5, 32'h1234_5678);
        bus.stall_i = 1'b1;
        drive(1'b1, 1'b1, 5'd6, 2'd0, 3'd0, 32'hBAD0_BAD0, '0, 32'h304);
        for (int unsigned i = 0; i < 3; i++) step("stall_hold", 1'b0, 5'd5, 32'h1234_5678);
        bus.stall_i = 1'b0;
        step("stall_release", 1'b1, 5'd6, 32'hBAD0_BAD0);
        idle("stall_idle");
    endtask

    task automatic test_flush_stall();
        drive(1'b1, 1'b1, 5'd6, 2'd0, 3'd0, 32'h0000_AAAA, '0, 32'h400);
        step("pre_flush", 1'b1, 5'd6, 32'h0000_AAAA);
        bus.flush_i = 1'b1;
        bus.stall_i = 1'b1;
        drive(1'b1, 1'b1, 5'd7, 2'd0, 3'd0, 32'h0000_BBBB, '0, 32'h404);
        step("flush_beats_stall", 1'b0, 5'd0, 32'h0);
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;
        idle("flush_idle");
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        logic [4:0]  r;
        for (int unsigned i = 0; i < 6; i++) begin
            v = $urandom;
            r = 5'($urandom_range(1, 31));
            drive(1'b1, 1'b1, r, 2'd0, 3'd0, v, $urandom, 32'h500 + 32'(i * 4));
            step("b2b_alu", 1'b1, r, v);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 5'd7, 2'd0, 3'd0, 32'h0000_7777, '0, 32'h600);
        step("mid_first", 1'b1, 5'd7, 32'h0000_7777);
        bus.stall_i = 1'b1;
        step("mid_stall", 1'b0, 5'd7, 32'h0000_7777);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset_mid_stall");
        m_valid   = 1'b0;
        m_written = 1'b0;
        m_cnt     = '0;
        @(negedge clk);
        rst_n       = 1'b1;
        bus.stall_i = 1'b0;
        idle("post_reset_idle");
    endtask

    initial begin
        test_reset();
        test_loads();
        test_link();
        test_r0();
        test_stall();
        test_flush_stall();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got unfinished exp finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register and write-back stage of the 5-stage MIPS datapath; drives the register file write port (reg_fileWr, Rw, busW).
- Captures MEM-stage results, aligns and extends load data, and selects the write-back source (ALU, memory, link).
- Provides a WB→ID/EX forwarding tap and a retired-instruction counter.
- Handles stall (hold without duplicate retire) and flush (bubble).

Parameters:
LINK_OFS, 4, byte offset added to the instruction PC to form the link address.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  reset; asynchronous assert, active-low.
stall_i  in  1  hold the MEM/WB register this cycle.
flush_i  in  1  load a bubble into the MEM/WB register this cycle.
mem_valid  in  1  MEM stage holds a real instruction.
mem_regwr  in  1  instruction writes a GPR.
mem_rw  in  5  destination register.
mem_wbsel  in  2  source select: 0 ALU, 1 MEM, 2 LINK, 3 reserved (treated as ALU).
mem_ldtype  in  3  load type: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5-7 treated as LW.
mem_alu_res  in  32  ALU result / effective address.
mem_rdata  in  32  raw data-memory word (little-endian lanes).
mem_pc  in  32  byte PC of the instruction.
reg_fileWr  out  1  register file write enable.
Rw  out  5  register file write address.
busW  out  32  register file write data.
wb_valid  out  1  WB holds a real instruction.
fwd_en  out  1  forwarding tap valid (equals reg_fileWr).
fwd_rw  out  5  forwarding destination (equals Rw).
fwd_data  out  32  forwarding data (equals busW, unscaled).
retire_cnt  out  CNT_W  count of retired instructions, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0, asynchronous): all pipeline fields cleared; wb_valid=0, reg_fileWr=0, Rw=0, busW=0, fwd_*=0, retire_cnt=0, internal written flag=0.
- Register update at posedge clk, priority order:
  - flush_i=1: bubble (valid=0, regwr=0, all data fields 0). Flush beats stall.
  - else stall_i=1: hold all fields; set written=1 if the held entry was valid.
  - else: capture all mem_* fields; written=0.
- Latency: MEM-stage inputs in cycle N appear on WB outputs in cycle N+1; the register file commits at the edge ending N+1.
- reg_fileWr = wb_valid & regwr & (Rw≠0) & ~written. A held entry writes exactly once; a write to r0 is never issued.
- Load alignment, combinational from registered rdata and addr[1:0]:
  - LW: word as-is.
  - LB/LBU: byte lane addr[1:0], sign- or zero-extended.
  - LH/LHU: halfword lane addr[1]; addr[0] ignored; sign- or zero-extended.
- LINK source: (pc + LINK_OFS) >> 2, i.e. word address. The register file scales r31 writes by 4, so busW carries word units for LINK. fwd_data equals busW, and ID/EX consumers apply the same scaling for r31.
- retire_cnt increments by 1 on each posedge where wb_valid=1 and written=0 before the edge. Each instruction counts once regardless of regwr or stall length. No increment for bubbles.
- Reset mid-stall: entry discarded, no write, counter cleared.

Test Plan:
- LB addr=0x1003, rdata=0x80FF_1234 → busW=0xFFFF_FF80, reg_fileWr=1 one cycle later. LBU, same inputs → busW=0x0000_0080.
- LH addr=0x2002, rdata=0x8001_7FFF → busW=0xFFFF_8001. LHU addr=0x2001 → busW=0x0000_7FFF (addr[0] ignored).
- LINK: wbsel=2, pc=0x0000_3000, rw=31 → busW=0x0000_0C01, Rw=31, fwd_data=0x0000_0C01.
- ALU write, rw=0, result=0xDEAD_BEEF → reg_fileWr=0, retire_cnt still +1.
- Valid ALU write to r5, then stall_i=1 for 3 cycles → reg_fileWr=1 on the first WB cycle only, then 0 for 3 cycles; retire_cnt +1 total.
- Both flush_i=1 and stall_i=1 → next cycle wb_valid=0, reg_fileWr=0. rst_n pulsed low mid-stream → all outputs 0 immediately, without a clock edge.
